// File: rtl/lane_unpack_pkg.sv
// Shared encodings and widths for the lane scatter unit and its lane extractor.
package lane_unpack_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NIB_LANES  = 4;
  localparam int unsigned BYTE_LANES = 2;

  localparam logic MODE_NIB  = 1'b0;
  localparam logic MODE_BYTE = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Index of the final lane for a given lane mode.
  function automatic logic [IDX_W-1:0] last_idx(input logic mode);
    return (mode == MODE_BYTE) ? IDX_W'(BYTE_LANES - 1) : IDX_W'(NIB_LANES - 1);
  endfunction

endpackage

// File: rtl/lane_unpack_extract.sv
// Combinational lane selector: picks lane[idx] of a packed word by mode and
// widens it to a full word with sign or zero extension.
module lane_extract
  import lane_unpack_pkg::*;
#(
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_mode,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [WORD_W-1:0] o_lane
);

  logic [NIB_W-1:0]  w_nib;
  logic [BYTE_W-1:0] w_byte;
  logic              w_nib_fill;
  logic              w_byte_fill;

  assign w_nib       = i_word[{i_idx, 2'b00} +: NIB_W];
  assign w_byte      = i_word[{i_idx[0], 3'b000} +: BYTE_W];
  assign w_nib_fill  = SIGN_EXT & w_nib[NIB_W-1];
  assign w_byte_fill = SIGN_EXT & w_byte[BYTE_W-1];

  assign o_lane = (i_mode == MODE_BYTE) ? {{(WORD_W-BYTE_W){w_byte_fill}}, w_byte}
                                        : {{(WORD_W-NIB_W){w_nib_fill}}, w_nib};

endmodule

// File: rtl/lane_unpack.sv
// Sequential scatter unit: accepts one packed word and emits its lanes one per
// handshake, LSB lane first, together with a running lane sum.
module lane_unpack
  import lane_unpack_pkg::*;
#(
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [WORD_W-1:0] out_sum
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word_nxt;
  logic              r_mode;
  logic              w_mode_nxt;
  logic [IDX_W-1:0]  r_count;
  logic [IDX_W-1:0]  w_count_nxt;
  logic [WORD_W-1:0] r_base;
  logic [WORD_W-1:0] w_base_nxt;

  logic [WORD_W-1:0] w_lane;
  logic [WORD_W-1:0] w_sum;
  logic              w_emit;
  logic              w_last;
  logic              w_out_fire;
  logic              w_accept;

  lane_extract #(
    .SIGN_EXT (SIGN_EXT)
  ) u_extract (
    .i_word (r_word),
    .i_mode (r_mode),
    .i_idx  (r_count),
    .o_lane (w_lane)
  );

  assign w_emit     = (r_state == ST_EMIT);
  assign w_last     = w_emit && (r_count == last_idx(r_mode));
  assign w_sum      = r_base + w_lane;
  assign w_out_fire = w_emit && out_ready;

  // A new word may land on the final-lane handshake, giving bubble-free words.
  assign in_ready = !flush && (!w_emit || (out_ready && w_last));
  assign w_accept = in_valid && in_ready;

  // Lane outputs are masked outside EMIT so a finished word never leaks out.
  assign out_valid = w_emit;
  assign out_data  = w_emit ? w_lane  : '0;
  assign out_idx   = w_emit ? r_count : '0;
  assign out_last  = w_last;
  assign out_sum   = w_emit ? w_sum   : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_mode_nxt  = r_mode;
    w_count_nxt = r_count;
    w_base_nxt  = r_base;
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
      w_base_nxt  = '0;
    end else if (w_accept) begin
      w_state_nxt = ST_EMIT;
      w_word_nxt  = in_word;
      w_mode_nxt  = in_mode;
      w_count_nxt = '0;
      w_base_nxt  = '0;
    end else if (w_out_fire) begin
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
        w_base_nxt  = '0;
      end else begin
        w_count_nxt = r_count + IDX_W'(1);
        w_base_nxt  = w_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_mode  <= MODE_NIB;
      r_count <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_mode  <= w_mode_nxt;
      r_count <= w_count_nxt;
      r_base  <= w_base_nxt;
    end
  end

endmodule

// File: tb/tb_lane_unpack.sv
// Directed bench for lane_unpack: a scoreboard of expected lanes is filled on
// every accepted word and drained on every lane handshake.
module tb_lane_unpack;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [15:0] in_word   = 16'h0;
  logic        in_mode   = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_last;
  logic [15:0] out_data, out_sum;
  logic [1:0]  out_idx;

  logic        z_in_ready, z_out_valid, z_out_last;
  logic [15:0] z_out_data, z_out_sum;
  logic [1:0]  z_out_idx;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] dz;
    logic [15:0] s;
    logic [15:0] sz;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lane_unpack dut (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready), .in_word (in_word), .in_mode (in_mode),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .out_idx (out_idx), .out_last (out_last), .out_sum (out_sum)
  );

  lane_unpack #(.SIGN_EXT(1'b0)) dut_z (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (z_in_ready), .in_word (in_word), .in_mode (in_mode),
    .out_valid (z_out_valid), .out_ready (out_ready), .out_data (z_out_data),
    .out_idx (z_out_idx), .out_last (z_out_last), .out_sum (z_out_sum)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference lane model for both extension flavours.
  task automatic push_word(input logic [15:0] w, input logic m);
    int          n;
    logic [15:0] s, sz, lz, ls;
    exp_t        e;
    n  = m ? 2 : 4;
    s  = 16'h0;
    sz = 16'h0;
    for (int i = 0; i < n; i++) begin
      if (m) begin
        lz = (w >> (8 * i)) & 16'h00FF;
        ls = lz[7] ? (lz | 16'hFF00) : lz;
      end else begin
        lz = (w >> (4 * i)) & 16'h000F;
        ls = lz[3] ? (lz | 16'hFFF0) : lz;
      end
      s  = s + ls;
      sz = sz + lz;
      e.d = ls; e.dz = lz; e.s = s; e.sz = sz;
      e.idx = 2'(i);
      e.last = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sb_underflow: observed=lane idx %0d expected=no lane", out_idx);
        end else begin
          e = sb.pop_front();
          chk("lane_data", out_data, e.d);
          chk("lane_idx", 16'(out_idx), 16'(e.idx));
          chk("lane_last", 16'(out_last), 16'(e.last));
          chk("lane_sum", out_sum, e.s);
          chk("z_valid", 16'(z_out_valid), 16'(1'b1));
          chk("z_lane_data", z_out_data, e.dz);
          chk("z_lane_idx", 16'(z_out_idx), 16'(e.idx));
          chk("z_lane_last", 16'(z_out_last), 16'(e.last));
          chk("z_lane_sum", z_out_sum, e.sz);
          chk("z_in_ready", 16'(z_in_ready), 16'(in_ready));
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) push_word(in_word, in_mode);
    end
  end

  task automatic offer(input logic [15:0] w, input logic m);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_word  = w;
    in_mode  = m;
    @(negedge clk);
    chk("offer_ready", 16'(in_ready), 16'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_last(input string tag, input logic [15:0] es, input logic [15:0] ez);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) begin
        got = 1'b1;
        chk(tag, out_sum, es);
        chk({tag, "_z"}, z_out_sum, ez);
      end
    end
    if (!got) begin
      total++;
      bad++;
      $error("FAIL %s_timeout: observed=no last lane expected=last lane within 20 cycles", tag);
    end
  endtask

  initial begin
    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_out_sum", out_sum, 16'h0);
    chk("rst_out_last", 16'(out_last), 16'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // nibble mode, sign and zero extension
    offer(16'h7F81, 1'b0);
    @(negedge clk);
    chk("nib_latency_valid", 16'(out_valid), 16'h1);
    chk("nib_first_idx", 16'(out_idx), 16'h0);
    chk("nib_first_data", out_data, 16'h0001);
    wait_last("nib_sum", 16'hFFFF, 16'h001F);

    // byte mode
    offer(16'h7F81, 1'b1);
    @(negedge clk);
    chk("byte_first_data", out_data, 16'hFF81);
    chk("byte_first_data_z", z_out_data, 16'h0081);
    wait_last("byte_sum", 16'h0000, 16'h0100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_word", 16'(out_valid), 16'h0);

    // backpressure on lane 1
    offer(16'h1234, 1'b0);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 16'(out_valid), 16'h1);
      chk("stall_data", out_data, 16'h0003);
      chk("stall_idx", 16'(out_idx), 16'h1);
      chk("stall_sum", out_sum, 16'h0007);
      chk("stall_in_ready", 16'(in_ready), 16'h0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_last("bp_sum", 16'h000A, 16'h000A);

    // back-to-back words
    offer(16'h1234, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_word  = 16'h00F0;
    in_mode  = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 16'(in_ready), 16'h1);
    chk("b2b_first_last", 16'(out_last), 16'h1);
    chk("b2b_first_sum", out_sum, 16'h0046);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_no_bubble", 16'(out_valid), 16'h1);
    chk("b2b_data", out_data, 16'hFFF0);
    chk("b2b_idx", 16'(out_idx), 16'h0);
    wait_last("b2b_sum", 16'hFFF0, 16'h00F0);

    // flush during lane 2, with a competing word offered
    offer(16'h8888, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_word  = 16'h0011;
    in_mode  = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 16'(in_ready), 16'h0);
    chk("flush_idx", 16'(out_idx), 16'h2);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_valid_drop", 16'(out_valid), 16'h0);
    chk("flush_ready_back", 16'(in_ready), 16'h1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("flush_next_idx", 16'(out_idx), 16'h0);
    chk("flush_next_data", out_data, 16'h0001);
    chk("flush_next_sum0", out_sum, 16'h0001);
    wait_last("flush_next_sum", 16'h0002, 16'h0002);

    // asynchronous reset mid-word
    offer(16'h4321, 1'b0);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(out_valid), 16'h0);
    chk("arst_in_ready", 16'(in_ready), 16'h1);
    chk("arst_data", out_data, 16'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst_no_stale", 16'(out_valid), 16'h0);
    end
    offer(16'h0005, 1'b1);
    @(negedge clk);
    chk("arst_next_idx", 16'(out_idx), 16'h0);
    chk("arst_next_data", out_data, 16'h0005);
    chk("arst_next_sum0", out_sum, 16'h0005);
    wait_last("arst_next_sum", 16'h0005, 16'h0005);

    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_empty", 16'(sb.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
